// File: rtl/core_bus_arbiter.sv
// Shares one memory bus between the instruction-fetch and data ports.
// At most one bus transaction is in flight; each ends with a one-cycle ready pulse.
module core_bus_arbiter #(
    parameter int DATA_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [63:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_data,
    input  logic        d_valid,
    input  logic [63:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [7:0]  d_strobe,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        c_valid,
    output logic        c_is_write,
    output logic [63:0] c_addr,
    output logic [2:0]  c_size,
    output logic [7:0]  c_strobe,
    output logic [63:0] c_wdata,
    input  logic        c_ready,
    input  logic [63:0] c_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

    state_e      state_q, state_d;
    logic        lastGrantD_q, lastGrantD_d;
    logic [63:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [7:0]  strobe_q, strobe_d;
    logic [63:0] wdata_q, wdata_d;
    logic        fetchHi_q, fetchHi_d;
    logic [31:0] iData_q, iData_d;
    logic [63:0] dRdata_q, dRdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lastGrantD_q <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            strobe_q     <= '0;
            wdata_q      <= '0;
            fetchHi_q    <= 1'b0;
            iData_q      <= '0;
            dRdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            lastGrantD_q <= lastGrantD_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            strobe_q     <= strobe_d;
            wdata_q      <= wdata_d;
            fetchHi_q    <= fetchHi_d;
            iData_q      <= iData_d;
            dRdata_q     <= dRdata_d;
        end
    end

    // lastGrantD_q doubles as the owner of the transaction while BUSY/RESP,
    // since it is only rewritten when a new grant is made from IDLE.
    always_comb begin
        state_d      = state_q;
        lastGrantD_d = lastGrantD_q;
        addr_d       = addr_q;
        size_d       = size_q;
        strobe_d     = strobe_q;
        wdata_d      = wdata_q;
        fetchHi_d    = fetchHi_q;
        iData_d      = iData_q;
        dRdata_d     = dRdata_q;
        case (state_q)
            IDLE: begin
                if (d_valid && (!i_valid || DATA_PRIO != 0 || !lastGrantD_q)) begin
                    state_d      = BUSY_D;
                    lastGrantD_d = 1'b1;
                    addr_d       = d_addr;
                    size_d       = d_size;
                    strobe_d     = d_strobe;
                    wdata_d      = d_wdata;
                    fetchHi_d    = 1'b0;
                end else if (i_valid) begin
                    state_d      = BUSY_I;
                    lastGrantD_d = 1'b0;
                    addr_d       = i_addr;
                    size_d       = 3'd2;
                    strobe_d     = 8'h00;
                    wdata_d      = 64'h0;
                    fetchHi_d    = i_addr[2];
                end
            end
            BUSY_I: begin
                if (c_ready) begin
                    iData_d = fetchHi_q ? c_rdata[63:32] : c_rdata[31:0];
                    state_d = RESP;
                end
            end
            BUSY_D: begin
                if (c_ready) begin
                    dRdata_d = c_rdata;
                    state_d  = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign c_valid    = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign c_is_write = |strobe_q;
    assign c_addr     = addr_q;
    assign c_size     = size_q;
    assign c_strobe   = strobe_q;
    assign c_wdata    = wdata_q;
    assign i_ready    = (state_q == RESP) && !lastGrantD_q;
    assign d_ready    = (state_q == RESP) && lastGrantD_q;
    assign i_data     = iData_q;
    assign d_rdata    = dRdata_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Self-checking bench for core_bus_arbiter: directed scenarios plus random traffic
// compared against a transaction-level model of the arbitration rules.
module tb_core_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0, d_valid = 1'b0, c_ready = 1'b0;
    logic [63:0] i_addr = '0, d_addr = '0, d_wdata = '0, c_rdata = '0;
    logic [2:0]  d_size = '0;
    logic [7:0]  d_strobe = '0;
    logic        i_ready, d_ready, c_valid, c_is_write;
    logic [31:0] i_data;
    logic [63:0] d_rdata, c_addr, c_wdata;
    logic [2:0]  c_size;
    logic [7:0]  c_strobe;

    logic        p_i_valid = 1'b0, p_d_valid = 1'b0;
    logic [63:0] p_i_addr = '0, p_d_addr = '0;
    logic        p_i_ready, p_d_ready, p_c_valid, p_c_is_write;
    logic [31:0] p_i_data;
    logic [63:0] p_d_rdata, p_c_addr, p_c_wdata;
    logic [2:0]  p_c_size;
    logic [7:0]  p_c_strobe;
    logic [63:0] p_c_rdata = 64'h1234_5678_9ABC_DEF0;

    always #5 clk = ~clk;

    core_bus_arbiter #(.DATA_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
        .c_valid(c_valid), .c_is_write(c_is_write), .c_addr(c_addr), .c_size(c_size),
        .c_strobe(c_strobe), .c_wdata(c_wdata), .c_ready(c_ready), .c_rdata(c_rdata)
    );

    // Data-priority instance with a memory that completes in the first bus cycle.
    core_bus_arbiter #(.DATA_PRIO(1)) dutPrio (
        .clk(clk), .rst(rst),
        .i_valid(p_i_valid), .i_addr(p_i_addr), .i_ready(p_i_ready), .i_data(p_i_data),
        .d_valid(p_d_valid), .d_addr(p_d_addr), .d_size(3'd3), .d_strobe(8'h00),
        .d_wdata(64'h0), .d_ready(p_d_ready), .d_rdata(p_d_rdata),
        .c_valid(p_c_valid), .c_is_write(p_c_is_write), .c_addr(p_c_addr), .c_size(p_c_size),
        .c_strobe(p_c_strobe), .c_wdata(p_c_wdata), .c_ready(p_c_valid), .c_rdata(p_c_rdata)
    );

    int checks = 0;
    int failures = 0;

    // Requester intents (index 0 = fetch, 1 = data) and the transaction-level model.
    bit          reqPend [2];
    logic [63:0] reqAddr [2];
    logic [2:0]  reqSize [2];
    logic [7:0]  reqStrobe [2];
    logic [63:0] reqWdata [2];

    bit          mdlBusy, mdlResp, mdlLastD, expHi;
    int          mdlSide;
    logic [63:0] expAddr, expWdata, expDData;
    logic [2:0]  expSize;
    logic [7:0]  expStrobe;
    logic [31:0] expIData;

    int          memWait = 0;
    int          memLatFixed = -1;
    bit          memForce = 0, memDataFixed = 0, spurious = 0;
    logic [63:0] memDataVal = '0;
    int          cycleCnt = 0;
    logic [63:0] grantLog [$];
    int          grantCycle [$];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic newReq(input int s, input logic [63:0] addr, input logic [2:0] size,
                          input logic [7:0] strobe, input logic [63:0] wdata);
        reqPend[s]   = 1'b1;
        reqAddr[s]   = addr;
        reqSize[s]   = size;
        reqStrobe[s] = strobe;
        reqWdata[s]  = wdata;
    endtask

    task automatic modelReset();
        mdlBusy = 0; mdlResp = 0; mdlLastD = 0; expHi = 0; mdlSide = 0;
        expAddr = '0; expWdata = '0; expDData = '0; expSize = '0; expStrobe = '0; expIData = '0;
        reqPend[0] = 0; reqPend[1] = 0;
        memWait = 0;
    endtask

    // One clock: drive at negedge, advance the model across the posedge, check at posedge+1.
    task automatic applyStimulus();
        bit cr;
        int w;
        bit newGrant;
        @(negedge clk);
        cycleCnt++;
        i_valid  = reqPend[0];
        i_addr   = reqAddr[0];
        d_valid  = reqPend[1];
        d_addr   = reqAddr[1];
        d_size   = reqSize[1];
        d_strobe = reqStrobe[1];
        d_wdata  = reqWdata[1];
        cr = memForce || (mdlBusy && memWait == 0) ||
             (!mdlBusy && spurious && $urandom_range(0, 3) == 0);
        c_ready = cr;
        c_rdata = memDataFixed ? memDataVal : {$urandom, $urandom};
        if (mdlBusy && memWait > 0) memWait--;

        newGrant = 0;
        if (mdlResp) begin
            mdlResp = 0;
            reqPend[mdlSide] = 0;
        end else if (mdlBusy) begin
            if (cr) begin
                if (mdlSide == 0) expIData = expHi ? c_rdata[63:32] : c_rdata[31:0];
                else              expDData = c_rdata;
                mdlBusy = 0;
                mdlResp = 1;
            end
        end else if (reqPend[0] || reqPend[1]) begin
            if (reqPend[0] && reqPend[1]) w = mdlLastD ? 0 : 1;
            else                          w = reqPend[1] ? 1 : 0;
            mdlSide  = w;
            mdlLastD = (w == 1);
            mdlBusy  = 1;
            newGrant = 1;
            expAddr  = reqAddr[w];
            if (w == 0) begin
                expSize = 3'd2; expStrobe = 8'h00; expWdata = 64'h0; expHi = reqAddr[0][2];
            end else begin
                expSize = reqSize[1]; expStrobe = reqStrobe[1]; expWdata = reqWdata[1];
            end
            memWait = (memLatFixed >= 0) ? memLatFixed : $urandom_range(0, 4);
        end

        @(posedge clk);
        #1;
        checkOutput("c_valid", c_valid, mdlBusy);
        if (mdlBusy) begin
            checkOutput("c_addr", c_addr, expAddr);
            checkOutput("c_size", c_size, expSize);
            checkOutput("c_strobe", c_strobe, expStrobe);
            checkOutput("c_wdata", c_wdata, expWdata);
            checkOutput("c_is_write", c_is_write, expStrobe != 0);
        end
        checkOutput("i_ready", i_ready, mdlResp && mdlSide == 0);
        checkOutput("d_ready", d_ready, mdlResp && mdlSide == 1);
        checkOutput("i_data", i_data, expIData);
        checkOutput("d_rdata", d_rdata, expDData);
        if (newGrant) begin
            grantLog.push_back(c_addr);
            grantCycle.push_back(cycleCnt);
        end
    endtask

    // Reset asserts immediately (asynchronously) and releases at a falling edge.
    task automatic doReset(input bit readyDuring);
        rst = 1'b1;
        i_valid = 0; d_valid = 0; c_ready = readyDuring;
        #1;
        checkOutput("rst_c_valid", c_valid, 0);
        checkOutput("rst_i_ready", i_ready, 0);
        checkOutput("rst_d_ready", d_ready, 0);
        checkOutput("rst_i_data", i_data, 0);
        checkOutput("rst_d_rdata", d_rdata, 0);
        checkOutput("rst_c_addr", c_addr, 0);
        checkOutput("rst_c_wdata", c_wdata, 0);
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        c_ready = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (mdlBusy || mdlResp || reqPend[0] || reqPend[1]); k++)
            applyStimulus();
        checkOutput("drain_timeout", mdlBusy || mdlResp || reqPend[0] || reqPend[1], 0);
    endtask

    initial begin
        int pDready;
        logic [63:0] pLog [$];
        logic [63:0] tieExp [4];

        modelReset();
        doReset(1'b0);

        // Single fetch from the upper word of a doubleword.
        memLatFixed = 2; memDataFixed = 1; memDataVal = 64'h1111_2222_3333_4444;
        newReq(0, 64'h8000_0004, 3'd0, 8'h00, 64'h0);
        applyStimulus();
        checkOutput("fetch_c_size", c_size, 3'd2);
        checkOutput("fetch_c_strobe", c_strobe, 8'h00);
        drain();
        checkOutput("fetch_i_data", i_data, 32'h1111_2222);

        // Single store.
        newReq(1, 64'h0000_1000, 3'd3, 8'hFF, 64'hDEAD_BEEF_0000_0001);
        applyStimulus();
        checkOutput("store_is_write", c_is_write, 1'b1);
        checkOutput("store_wdata", c_wdata, 64'hDEAD_BEEF_0000_0001);
        drain();
        memDataFixed = 0;

        // Long stall with both sides waiting; last grant was data, so fetch goes first.
        memLatFixed = 20;
        grantLog.delete();
        newReq(0, 64'h0000_2000, 3'd0, 8'h00, 64'h0);
        newReq(1, 64'h0000_3000, 3'd2, 8'h00, 64'h0);
        drain();
        checkOutput("stall_first", grantLog.size() > 0 ? grantLog[0] : 64'h0, 64'h2000);
        memLatFixed = -1;

        // Continuous tie after reset alternates D, I, D, I.
        doReset(1'b0);
        grantLog.delete();
        for (int k = 0; k < 200 && grantLog.size() < 4; k++) begin
            if (!reqPend[0]) newReq(0, 64'h1000, 3'd0, 8'h00, 64'h0);
            if (!reqPend[1]) newReq(1, 64'h2000, 3'd3, 8'h00, 64'h0);
            applyStimulus();
        end
        tieExp[0] = 64'h2000; tieExp[1] = 64'h1000; tieExp[2] = 64'h2000; tieExp[3] = 64'h1000;
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("tie_grant%0d", k), k < grantLog.size() ? grantLog[k] : 64'h0, tieExp[k]);
        drain();

        // Back-to-back fetches with a zero-wait memory: grants three cycles apart.
        memLatFixed = 0;
        grantCycle.delete();
        for (int k = 0; k < 40 && grantCycle.size() < 2; k++) begin
            if (!reqPend[0]) newReq(0, 64'h4000 + 64'(k * 8), 3'd0, 8'h00, 64'h0);
            applyStimulus();
        end
        checkOutput("b2b_gap", grantCycle.size() >= 2 ? grantCycle[1] - grantCycle[0] : 0, 3);
        drain();

        // Reset in the middle of a data transaction, with c_ready during and after reset.
        memLatFixed = 5;
        newReq(1, 64'h5000, 3'd3, 8'h0F, 64'h55);
        applyStimulus();
        checkOutput("busy_before_rst", c_valid, 1'b1);
        doReset(1'b1);
        memForce = 1;
        applyStimulus();
        memForce = 0;
        applyStimulus();
        checkOutput("rst_no_dready", d_ready, 1'b0);
        memLatFixed = -1;

        // Random traffic, including spurious c_ready and requesters dropping valid mid-transaction.
        spurious = 1;
        for (int k = 0; k < 600; k++) begin
            for (int s = 0; s < 2; s++) begin
                if (!reqPend[s] && !(mdlResp && mdlSide == s) && $urandom_range(0, 2) == 0)
                    newReq(s, {$urandom, $urandom}, 3'($urandom_range(0, 3)),
                           ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom),
                           {$urandom, $urandom});
            end
            if (mdlBusy && reqPend[mdlSide] && $urandom_range(0, 15) == 0) reqPend[mdlSide] = 0;
            applyStimulus();
        end
        spurious = 0;
        drain();

        // Data priority: data wins every tie while it stays valid, fetch only after it drops.
        @(negedge clk);
        p_i_addr = 64'hA0; p_d_addr = 64'hB0;
        p_i_valid = 1; p_d_valid = 1;
        pDready = 0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            if (p_c_valid) pLog.push_back(p_c_addr);
            if (p_d_ready) pDready++;
            checkOutput("prio_excl", p_i_ready & p_d_ready, 1'b0);
            if (k == 9) begin
                @(negedge clk);
                p_d_valid = 0;
            end
        end
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("prio_d%0d", k), k < pLog.size() ? pLog[k] : 64'h0, 64'hB0);
        checkOutput("prio_i_after", pLog.size() > 3 ? pLog[3] : 64'h0, 64'hA0);
        checkOutput("prio_d_pulses", pDready, 3);
        checkOutput("prio_i_data", p_i_data, 32'h9ABC_DEF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_bus_arbiter.md
CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 SHALL have parameter DATA_PRIO, default 0; 0 = round-robin on simultaneous requests, 1 = data side always wins.
REQ-002 SHALL have clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have i_valid  input  1  instruction-fetch request pending; i_addr  input  64  fetch address.
REQ-005 SHALL have i_ready  output  1  one-cycle fetch completion pulse; i_data  output  32  fetched instruction, valid while i_ready.
REQ-006 SHALL have d_valid  input  1  data request pending; d_addr  input  64  address; d_size  input  3  log2 bytes; d_strobe  input  8  byte-write mask, all-zero = read; d_wdata  input  64  store data.
REQ-007 SHALL have d_ready  output  1  one-cycle data completion pulse; d_rdata  output  64  load data, valid while d_ready.
REQ-008 SHALL have c_valid, c_is_write  output  1 each; c_addr  output  64; c_size  output  3; c_strobe  output  8; c_wdata  output  64  shared memory-bus request.
REQ-009 SHALL have c_ready  input  1  shared-bus completion; c_rdata  input  64  shared-bus read data, valid while c_ready.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP.
REQ-011 IDLE: i_valid only -> BUSY_I; d_valid only -> BUSY_D; neither -> stay IDLE.
REQ-012 IDLE with both valid: DATA_PRIO=1 -> BUSY_D; DATA_PRIO=0 -> side not granted last (last_grant register, reset value I, so D wins first tie).
REQ-013 On entering BUSY_x SHALL latch the winning request fields into holding registers and update last_grant; c_* outputs SHALL be driven only from holding registers.
REQ-014 c_valid SHALL be 1 exactly while in BUSY_I or BUSY_D; c_is_write = 1 iff latched strobe nonzero; fetch requests drive c_size=3'd2, c_strobe=0, c_wdata=0.
REQ-015 c_* outputs SHALL remain stable in BUSY_x until c_ready is sampled high.
REQ-016 BUSY_x with c_ready=1 SHALL capture c_rdata (fetch: low 32 bits when i_addr[2]=0, high 32 bits when i_addr[2]=1) into response register and go to RESP; c_ready=0 -> stay.
REQ-017 RESP SHALL assert exactly one of i_ready/d_ready (the granted side) for one cycle, then return to IDLE.
REQ-018 Minimum latency: request in IDLE at edge N -> c_valid from cycle N+1; c_ready at edge M -> x_ready high in cycle M+1.
REQ-019 Requesters hold valid and fields stable until they sample ready; arbiter SHALL ignore fields after latching.
REQ-020 A requester dropping valid during BUSY_x SHALL NOT abort the bus transaction; the RESP pulse is still issued.
REQ-021 The other side's request SHALL wait untouched; no new grant during BUSY_x or RESP.
REQ-022 Arbiter SHALL never have more than one outstanding shared-bus transaction; i_ready and d_ready SHALL never be high together.
REQ-023 i_data/d_rdata SHALL hold the last response value when ready is low.

Reset
REQ-024 rst high SHALL immediately force state IDLE, c_valid=0, i_ready=0, d_ready=0, last_grant=I, holding and response registers zero.
REQ-025 Reset mid-transaction SHALL discard the transaction; a c_ready arriving during or after reset in IDLE SHALL be ignored.
REQ-026 First request after reset deassertion SHALL be sampled at the first rising edge with rst low.

Verification
REQ-027 Fetch only: i_valid, i_addr=0x8000_0004, c_ready 3 cycles later with c_rdata=0x1111_2222_3333_4444 -> c_size=2, c_strobe=0, i_data=0x1111_2222, one-cycle i_ready.
REQ-028 Store only: d_strobe=0xFF, d_wdata=0xDEAD_BEEF_0000_0001 -> c_is_write=1, c_wdata matches, d_ready one pulse, i_ready stays 0.
REQ-029 Tie, DATA_PRIO=0, both held valid continuously -> grants D,I,D,I alternating; DATA_PRIO=1 -> D granted first, then I only after D valid drops.
REQ-030 c_ready held low 20 cycles -> c_* stable all 20 cycles, no ready pulse, second requester not granted.
REQ-031 rst asserted while BUSY_D with c_ready=0 -> c_valid=0 same cycle; c_ready pulse afterwards produces no d_ready.
REQ-032 Back-to-back fetches, i_valid re-asserted in cycle after i_ready -> one IDLE cycle between RESP and next BUSY_I.
